hazard_ctrl: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/hazard_ctrl.sv | 117 +++++++++++
 tb/tb_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, data word and hazard controller states.
package cpu_types_pkg;

    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN,
        DWAIT,
        HALTED
    } hz_state_t;

    localparam word_t STALL_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: arbitrates data/instruction misses, redirects and
// load-use hazards into per-stage enable/flush controls; tracks halt and stalls.
module hazard_ctrl
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     RST,
    input  logic     ihit,
    input  logic     dhit,
    input  logic     mem_dreq,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    input  logic     id_uses_rs,
    input  logic     id_uses_rt,
    input  logic     ex_dREN,
    input  regbits_t ex_wsel,
    input  logic     ex_redirect,
    input  logic     wb_halt,
    output logic     pc_en,
    output logic     ifid_en,
    output logic     idex_en,
    output logic     exmem_en,
    output logic     memwb_en,
    output logic     ifid_flush,
    output logic     idex_flush,
    output logic     exmem_flush,
    output logic     memwb_flush,
    output logic     halt,
    output word_t    stall_cnt
);

    hz_state_t state;
    hz_state_t next_state;
    logic      dmiss;
    logic      load_use;
    logic      halted_now;

    assign dmiss    = mem_dreq & ~dhit;
    // A load targeting $0 never produces a value worth waiting for.
    assign load_use = ex_dREN & (ex_wsel != '0) &
                      ((id_uses_rs & (id_rs == ex_wsel)) |
                       (id_uses_rt & (id_rt == ex_wsel)));

    // During a reset cycle the outputs behave as in RUN.
    assign halted_now = (state == HALTED) & ~RST;
    assign halt       = (state == HALTED);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN, DWAIT: begin
                if (wb_halt) begin
                    next_state = HALTED;
                end else if (dmiss) begin
                    next_state = DWAIT;
                end else begin
                    next_state = RUN;
                end
            end
            HALTED:  next_state = HALTED;
            default: next_state = RUN;
        endcase
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (halted_now || wb_halt) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (dmiss) begin
            // Freeze upstream; MEM/WB takes a bubble while the data access waits.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt <= '0;
        end else if (!pc_en && state != HALTED && stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic checked against a rule-level reference model.
module tb_hazard_ctrl;
    import cpu_types_pkg::*;

    logic     CLK = 1'b0;
    logic     RST;
    logic     ihit, dhit, mem_dreq;
    regbits_t id_rs, id_rt;
    logic     id_uses_rs, id_uses_rt;
    logic     ex_dREN;
    regbits_t ex_wsel;
    logic     ex_redirect, wb_halt;
    logic     pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic     ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic     halt;
    word_t    stall_cnt;

    int total = 0;
    int bad   = 0;

    bit    m_halted;
    word_t m_cnt;

    localparam logic [8:0] V_DEFAULT  = 9'b111110000;
    localparam logic [8:0] V_FREEZE   = 9'b000010001;
    localparam logic [8:0] V_REDIRECT = 9'b111111100;
    localparam logic [8:0] V_LOADUSE  = 9'b001110100;
    localparam logic [8:0] V_IMISS    = 9'b011111000;
    localparam logic [8:0] V_STOP     = 9'b000000000;

    wire [8:0] ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                       ifid_flush, idex_flush, exmem_flush, memwb_flush};

    hazard_ctrl dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .ex_redirect(ex_redirect), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .halt(halt), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    // Expected controls straight from the priority rules; halted is the model's view.
    function automatic logic [8:0] model_ctrl(bit halted_now);
        bit lu;
        lu = ex_dREN && ex_wsel != 0 &&
             ((id_uses_rs && id_rs == ex_wsel) || (id_uses_rt && id_rt == ex_wsel));
        if (halted_now || wb_halt) return V_STOP;
        if (mem_dreq && !dhit)     return V_FREEZE;
        if (ex_redirect)           return V_REDIRECT;
        if (lu)                    return V_LOADUSE;
        if (!ihit)                 return V_IMISS;
        return V_DEFAULT;
    endfunction

    task automatic idle_inputs();
        RST = 0; ihit = 1; dhit = 1; mem_dreq = 0;
        id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_dREN = 0; ex_wsel = 0; ex_redirect = 0; wb_halt = 0;
    endtask

    // Moves the model across the coming rising edge, then waits for it.
    task automatic advance();
        logic [8:0] e;
        e = model_ctrl(m_halted && !RST);
        if (RST) begin
            m_halted = 0;
            m_cnt    = 0;
        end else if (!m_halted) begin
            if (!e[8] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (wb_halt) m_halted = 1;
        end
        @(posedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK); idle_inputs(); RST = 1;
        advance();
        @(negedge CLK); RST = 0;
    endtask

    task automatic test_reset();
        @(negedge CLK); idle_inputs(); RST = 1; wb_halt = 1;
        #1;
        total++; if (ctrl !== V_STOP) begin bad++; $display("FAIL reset_cycle_halt_rule: got %b expected %b", ctrl, V_STOP); end
        advance();
        @(negedge CLK); idle_inputs(); #1;
        total++; if (halt !== 1'b0) begin bad++; $display("FAIL reset_halt: got %b expected 0", halt); end
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt); end
        total++; if (ctrl !== V_DEFAULT) begin bad++; $display("FAIL reset_defaults: got %b expected %b", ctrl, V_DEFAULT); end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_dREN = 1; ex_wsel = 5; id_rs = 5; id_uses_rs = 1; #1;
        total++; if (ctrl !== V_LOADUSE) begin bad++; $display("FAIL load_use_rs: got %b expected %b", ctrl, V_LOADUSE); end
        advance();
        @(negedge CLK); idle_inputs(); #1;
        total++; if (ctrl !== V_DEFAULT) begin bad++; $display("FAIL load_use_release: got %b expected %b", ctrl, V_DEFAULT); end
        total++; if (stall_cnt !== 32'd1) begin bad++; $display("FAIL load_use_cnt: got %0d expected 1", stall_cnt); end
        ex_dREN = 1; ex_wsel = 9; id_rt = 9; id_uses_rt = 1; id_rs = 9; #1;
        total++; if (ctrl !== V_LOADUSE) begin bad++; $display("FAIL load_use_rt: got %b expected %b", ctrl, V_LOADUSE); end
        id_uses_rt = 0; #1;
        total++; if (ctrl !== V_DEFAULT) begin bad++; $display("FAIL load_use_unused_src: got %b expected %b", ctrl, V_DEFAULT); end
        ex_wsel = 0; id_rs = 0; id_rt = 0; id_uses_rs = 1; id_uses_rt = 1; #1;
        total++; if (ctrl !== V_DEFAULT) begin bad++; $display("FAIL load_use_r0: got %b expected %b", ctrl, V_DEFAULT); end
        ex_wsel = 3; id_rs = 3; ex_redirect = 1; #1;
        total++; if (ctrl !== V_REDIRECT) begin bad++; $display("FAIL load_use_vs_redirect: got %b expected %b", ctrl, V_REDIRECT); end
        idle_inputs();
    endtask

    task automatic test_dmiss(input bit with_redirect);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            mem_dreq = 1; dhit = 0; ex_redirect = with_redirect; #1;
            total++; if (ctrl !== V_FREEZE) begin bad++; $display("FAIL dmiss_freeze[%0d]: got %b expected %b", i, ctrl, V_FREEZE); end
            advance();
            @(negedge CLK); #1;
            total++; if (dut.state !== DWAIT) begin bad++; $display("FAIL dmiss_state[%0d]: got %0d expected %0d", i, dut.state, DWAIT); end
        end
        dhit = 1; #1;
        total++; if (ctrl !== (with_redirect ? V_REDIRECT : V_DEFAULT)) begin
            bad++; $display("FAIL dmiss_release: got %b expected %b", ctrl, with_redirect ? V_REDIRECT : V_DEFAULT);
        end
        advance();
        @(negedge CLK); idle_inputs(); #1;
        total++; if (stall_cnt !== 32'd3) begin bad++; $display("FAIL dmiss_cnt: got %0d expected 3", stall_cnt); end
        total++; if (dut.state !== RUN) begin bad++; $display("FAIL dmiss_exit_state: got %0d expected %0d", dut.state, RUN); end
    endtask

    task automatic test_imiss();
        do_reset();
        ihit = 0; ex_redirect = 1; #1;
        total++; if (ctrl !== V_REDIRECT) begin bad++; $display("FAIL imiss_redirect: got %b expected %b", ctrl, V_REDIRECT); end
        ex_redirect = 0; #1;
        total++; if (ctrl !== V_IMISS) begin bad++; $display("FAIL imiss_alone: got %b expected %b", ctrl, V_IMISS); end
        idle_inputs();
    endtask

    task automatic test_halt();
        do_reset();
        wb_halt = 1; #1;
        total++; if (ctrl !== V_STOP) begin bad++; $display("FAIL halt_entry: got %b expected %b", ctrl, V_STOP); end
        advance();
        @(negedge CLK); wb_halt = 0; #1;
        total++; if (halt !== 1'b1) begin bad++; $display("FAIL halt_sticky: got %b expected 1", halt); end
        for (int i = 0; i < 4; i++) begin
            ihit = i[0]; dhit = i[1]; mem_dreq = i[0]; #1;
            total++; if (ctrl !== V_STOP) begin bad++; $display("FAIL halted_ctrl[%0d]: got %b expected %b", i, ctrl, V_STOP); end
            advance();
            @(negedge CLK);
        end
        #1;
        total++; if (stall_cnt !== 32'd1) begin bad++; $display("FAIL halted_cnt: got %0d expected 1", stall_cnt); end
        total++; if (halt !== 1'b1) begin bad++; $display("FAIL halt_held: got %b expected 1", halt); end
        idle_inputs(); RST = 1; #1;
        total++; if (ctrl !== V_DEFAULT) begin bad++; $display("FAIL halt_reset_cycle: got %b expected %b", ctrl, V_DEFAULT); end
        advance();
        @(negedge CLK); RST = 0; #1;
        total++; if (halt !== 1'b0 || stall_cnt !== 32'd0) begin
            bad++; $display("FAIL halt_cleared: got halt=%b cnt=%0d expected halt=0 cnt=0", halt, stall_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        force dut.stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt;
        m_cnt = 32'hFFFF_FFFE;
        ihit = 0;
        for (int i = 0; i < 3; i++) begin
            advance();
            @(negedge CLK); #1;
        end
        total++; if (stall_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL saturate: got %h expected ffffffff", stall_cnt); end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [8:0] e;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            RST         = ($urandom_range(0, 59) == 0);
            wb_halt     = ($urandom_range(0, 39) == 0);
            ihit        = ($urandom_range(0, 99) < 75);
            dhit        = ($urandom_range(0, 99) < 60);
            mem_dreq    = ($urandom_range(0, 99) < 30);
            ex_redirect = ($urandom_range(0, 99) < 15);
            ex_dREN     = ($urandom_range(0, 99) < 40);
            ex_wsel     = 5'($urandom_range(0, 3));
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            id_uses_rs  = $urandom_range(0, 1) == 1;
            id_uses_rt  = $urandom_range(0, 1) == 1;
            #1;
            e = model_ctrl(m_halted && !RST);
            total++; if (ctrl !== e || halt !== m_halted || stall_cnt !== m_cnt) begin
                bad++;
                $display("FAIL random[%0d]: got ctrl=%b halt=%b cnt=%0d expected ctrl=%b halt=%b cnt=%0d",
                         n, ctrl, halt, stall_cnt, e, m_halted, m_cnt);
            end
            advance();
            @(negedge CLK);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        m_halted = 0;
        m_cnt    = 0;
        test_reset();
        test_load_use();
        test_dmiss(1'b0);
        test_dmiss(1'b1);
        test_imiss();
        test_halt();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
